// File: rtl/dma_csr_pkg.sv
// Shared types and constants for the dma_csr_ctrl MMIO front end.
// The CCI-P subset here matches dma.vh so this slice builds on its own.
package dma_csr_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [15:0]  t_ccip_mmioAddr;
    typedef logic [63:0]  t_ccip_mmioData;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_clData        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    localparam logic [7:0] OFF_SRC    = 8'h00;
    localparam logic [7:0] OFF_DST    = 8'h08;
    localparam logic [7:0] OFF_RLEN   = 8'h10;
    localparam logic [7:0] OFF_WLEN   = 8'h18;
    localparam logic [7:0] OFF_CTRL   = 8'h20;
    localparam logic [7:0] OFF_STATUS = 8'h28;
    localparam logic [7:0] OFF_CYCLES = 8'h30;
    localparam logic [7:0] OFF_DONES  = 8'h38;

    localparam int ST_BUSY        = 0;
    localparam int ST_DONE        = 1;
    localparam int ST_ERR_WR_BUSY = 2;
    localparam int ST_ERR_ZERO    = 3;
    localparam int ST_ERR_LEN     = 4;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_BUSY,
        S_DONE
    } t_csr_state;

    // Register slots in offset order; R_NONE marks an unmapped access.
    typedef enum logic [3:0] {
        R_SRC,
        R_DST,
        R_RLEN,
        R_WLEN,
        R_CTRL,
        R_STATUS,
        R_CYCLES,
        R_DONES,
        R_NONE
    } t_csr_reg;

    function automatic t_csr_reg csr_decode(
        input logic [17:0] ba,
        input logic [15:0] base
    );
        logic [17:0] d;
        d = ba - {2'b00, base};
        if (ba < {2'b00, base} || d[2:0] != 3'd0 ||
            d > 18'(OFF_DONES))
            return R_NONE;
        return t_csr_reg'({1'b0, d[5:3]});
    endfunction

endpackage

// File: rtl/dma_csr_ctrl_if.sv
// MMIO request/response bundle between the host shim and dma_csr_ctrl.
interface dma_csr_ctrl_if;
    import dma_csr_pkg::*;

    t_if_ccip_c0_Rx sRx_c0;
    t_if_ccip_c2_Tx c2_tx;

    modport master (output sRx_c0, input c2_tx);
    modport slave  (input sRx_c0, output c2_tx);
endinterface

// File: rtl/dma_csr_ctrl.sv
// MMIO descriptor/control/status front end for the dma copy engine.
// Launches a copy, masks the early finished window, serves status reads.
module dma_csr_ctrl
    import dma_csr_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 3,
    parameter logic [15:0] CSR_BASE     = 16'h0020
) (
    input  logic          clk,
    input  logic          soft_reset,
    dma_csr_ctrl_if.slave mmio,
    output logic          begin_copy,
    output t_ccip_clAddr  rd_addr,
    output t_ccip_clAddr  wr_addr,
    output logic [63:0]   rd_len,
    output logic [63:0]   wr_len,
    input  logic          finished
);

    localparam logic [31:0] GUARD_LAST =
        (GUARD_CYCLES == 0) ? 32'd0 : 32'(GUARD_CYCLES - 1);

    t_csr_state     state;
    logic [31:0]    gcnt;
    t_ccip_clAddr   src;
    t_ccip_clAddr   dst;
    logic [63:0]    rlen;
    logic [63:0]    wlen;
    logic [63:0]    cycles;
    logic [63:0]    dones;
    logic           done;
    logic           err_wr_busy;
    logic           err_zero;
    logic           err_len;
    logic           rd_q;
    t_ccip_tid      rd_tid_q;
    t_csr_reg       rd_sel_q;
    t_if_ccip_c2_Tx rsp;

    t_ccip_c0_ReqMmioHdr hdr;
    t_csr_reg            sel;
    logic [63:0]         wdata;
    logic                wr_en;
    logic                rd_en;
    logic                busy;
    logic                zero_addr;
    logic                bad_len;
    logic                start_req;
    logic                clear_req;
    logic                desc_wr;
    logic [63:0]         status;
    logic [63:0]         rd_data;
    logic                unused;

    assign hdr   = mmio.sRx_c0.hdr;
    assign wr_en = mmio.sRx_c0.mmioWrValid;
    assign rd_en = mmio.sRx_c0.mmioRdValid;
    assign wdata = mmio.sRx_c0.data[63:0];
    assign sel   = csr_decode({hdr.address, 2'b00}, CSR_BASE);

    assign busy = (state == S_LAUNCH) || (state == S_GUARD) ||
                  (state == S_BUSY);
    assign zero_addr = (src == '0) || (dst == '0);
    assign bad_len   = wlen > rlen;
    assign start_req = wr_en && (sel == R_CTRL) && wdata[CTRL_START];
    assign clear_req = wr_en && (sel == R_CTRL) && wdata[CTRL_CLEAR];
    assign desc_wr   = wr_en && (sel == R_SRC || sel == R_DST ||
                                 sel == R_RLEN || sel == R_WLEN);

    assign rd_addr    = src;
    assign wr_addr    = dst;
    assign rd_len     = rlen;
    assign wr_len     = wlen;
    assign mmio.c2_tx = rsp;

    assign unused = ^{mmio.sRx_c0.data[511:64], hdr.length,
                      hdr.rsvd, mmio.sRx_c0.rspValid};

    always_comb begin
        status                 = '0;
        status[ST_BUSY]        = busy;
        status[ST_DONE]        = done;
        status[ST_ERR_WR_BUSY] = err_wr_busy;
        status[ST_ERR_ZERO]    = err_zero;
        status[ST_ERR_LEN]     = err_len;
    end

    always_comb begin
        rd_data = '0;
        unique case (rd_sel_q)
            R_SRC:    rd_data = 64'(src);
            R_DST:    rd_data = 64'(dst);
            R_RLEN:   rd_data = rlen;
            R_WLEN:   rd_data = wlen;
            R_STATUS: rd_data = status;
            R_CYCLES: rd_data = cycles;
            R_DONES:  rd_data = dones;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_reset) begin
            state       <= S_IDLE;
            gcnt        <= '0;
            src         <= '0;
            dst         <= '0;
            rlen        <= '0;
            wlen        <= '0;
            cycles      <= '0;
            dones       <= '0;
            done        <= 1'b0;
            err_wr_busy <= 1'b0;
            err_zero    <= 1'b0;
            err_len     <= 1'b0;
            begin_copy  <= 1'b0;
            rd_q        <= 1'b0;
            rd_tid_q    <= '0;
            rd_sel_q    <= R_NONE;
            rsp         <= '0;
        end else begin
            begin_copy <= 1'b0;
            if (busy && cycles != '1)
                cycles <= cycles + 64'd1;

            if (desc_wr && !busy) begin
                unique case (sel)
                    R_SRC:   src  <= wdata[41:0];
                    R_DST:   dst  <= wdata[41:0];
                    R_RLEN:  rlen <= wdata;
                    R_WLEN:  wlen <= wdata;
                    default: ;
                endcase
            end
            if (desc_wr && busy)
                err_wr_busy <= 1'b1;

            // Clear lands before start so a start error survives it.
            if (clear_req) begin
                done        <= 1'b0;
                err_wr_busy <= 1'b0;
                err_zero    <= 1'b0;
                err_len     <= 1'b0;
            end

            if (start_req) begin
                if (busy) begin
                    err_wr_busy <= 1'b1;
                end else begin
                    if (zero_addr)
                        err_zero <= 1'b1;
                    if (bad_len)
                        err_len <= 1'b1;
                    if (!zero_addr && !bad_len) begin
                        state      <= S_LAUNCH;
                        begin_copy <= 1'b1;
                        done       <= 1'b0;
                        cycles     <= '0;
                    end
                end
            end

            // A finish in the same cycle as a clear still reports DONE.
            unique case (state)
                S_LAUNCH: begin
                    gcnt  <= '0;
                    state <= (GUARD_CYCLES == 0) ? S_BUSY : S_GUARD;
                end
                S_GUARD: begin
                    if (gcnt == GUARD_LAST)
                        state <= S_BUSY;
                    else
                        gcnt <= gcnt + 32'd1;
                end
                S_BUSY: begin
                    if (finished) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        dones <= dones + 64'd1;
                    end
                end
                default: ;
            endcase

            rd_q     <= rd_en;
            rd_tid_q <= hdr.tid;
            rd_sel_q <= sel;

            rsp <= '0;
            if (rd_q) begin
                rsp.mmioRdValid <= 1'b1;
                rsp.hdr.tid     <= rd_tid_q;
                rsp.data        <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dma_csr_ctrl.sv
// Randomized bench for dma_csr_ctrl against a timeline-based
// reference model, plus directed scenarios with fixed expectations.
module tb_dma_csr_ctrl;
    import dma_csr_pkg::*;

    localparam int          G    = 3;
    localparam logic [15:0] BASE = 16'h0020;
    localparam logic [63:0] MASK42 = (64'd1 << 42) - 64'd1;

    logic         clk = 1'b0;
    logic         soft_reset;
    logic         begin_copy;
    logic         finished;
    t_ccip_clAddr rd_addr;
    t_ccip_clAddr wr_addr;
    logic [63:0]  rd_len;
    logic [63:0]  wr_len;

    dma_csr_ctrl_if mmio();

    dma_csr_ctrl #(.GUARD_CYCLES(G), .CSR_BASE(BASE)) dut (
        .clk        (clk),
        .soft_reset (soft_reset),
        .mmio       (mmio.slave),
        .begin_copy (begin_copy),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .rd_len     (rd_len),
        .wr_len     (wr_len),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    longint cyc = 0;
    logic [8:0]  rsp_tid_q[$];
    logic [63:0] rsp_data_q[$];

    // Reference model: registers plus the launch timestamp of the run.
    logic [63:0] m_src, m_dst, m_rlen, m_wlen, m_cyc, m_dones;
    bit          m_done, m_ewb, m_ez, m_el, m_run;
    longint      m_launch;
    bit          p_v, e_v;
    logic [8:0]  p_tid, e_tid;
    logic [15:0] p_a;
    logic [63:0] e_data;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] dw(input int off);
        int b;
        b = int'(BASE) + off;
        return 16'(b >>> 2);
    endfunction

    function automatic int byte_off(input logic [15:0] a);
        return int'({a, 2'b00}) - int'(BASE);
    endfunction

    function automatic logic [63:0] model_rd(input logic [15:0] a);
        case (byte_off(a))
            'h00: return m_src;
            'h08: return m_dst;
            'h10: return m_rlen;
            'h18: return m_wlen;
            'h28: return {59'd0, m_el, m_ez, m_ewb, m_done, m_run};
            'h30: return m_cyc;
            'h38: return m_dones;
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_rlen = 0; m_wlen = 0;
        m_cyc = 0; m_dones = 0;
        m_done = 0; m_ewb = 0; m_ez = 0; m_el = 0; m_run = 0;
        m_launch = -100;
        p_v = 0; e_v = 0; p_tid = 0; e_tid = 0; p_a = 0; e_data = 0;
    endtask

    task automatic model_step();
        bit wv, rv, was_run;
        logic [63:0] d;
        int off;
        wv  = mmio.sRx_c0.mmioWrValid;
        rv  = mmio.sRx_c0.mmioRdValid;
        d   = mmio.sRx_c0.data[63:0];
        off = byte_off(mmio.sRx_c0.hdr.address);
        if (soft_reset) begin
            model_reset();
            return;
        end
        e_v    = p_v;
        e_tid  = p_tid;
        e_data = p_v ? model_rd(p_a) : 64'd0;
        p_v    = rv;
        p_tid  = mmio.sRx_c0.hdr.tid;
        p_a    = mmio.sRx_c0.hdr.address;
        was_run = m_run;
        if (m_run && m_cyc != '1)
            m_cyc = m_cyc + 1;
        if (wv) begin
            if (off == 0 || off == 8 || off == 'h10 || off == 'h18) begin
                if (was_run) m_ewb = 1;
                else if (off == 0) m_src = d & MASK42;
                else if (off == 8) m_dst = d & MASK42;
                else if (off == 'h10) m_rlen = d;
                else m_wlen = d;
            end
            if (off == 'h20) begin
                if (d[1]) begin
                    m_done = 0; m_ewb = 0; m_ez = 0; m_el = 0;
                end
                if (d[0]) begin
                    if (was_run) m_ewb = 1;
                    else begin
                        if (m_src == 0 || m_dst == 0) m_ez = 1;
                        if (m_wlen > m_rlen) m_el = 1;
                        if (!(m_src == 0 || m_dst == 0) &&
                            !(m_wlen > m_rlen)) begin
                            m_run = 1; m_launch = cyc + 1;
                            m_cyc = 0; m_done = 0;
                        end
                    end
                end
            end
        end
        // finished only counts once the guard window has elapsed
        if (was_run && cyc >= m_launch + 1 + G && finished) begin
            m_run = 0; m_done = 1; m_dones = m_dones + 1;
        end
    endtask

    task automatic check_outputs();
        check_eq("begin_copy", 64'(begin_copy),
                 64'(m_run && cyc == m_launch));
        check_eq("rsp_valid", 64'(mmio.c2_tx.mmioRdValid), 64'(e_v));
        if (e_v) begin
            check_eq("rsp_tid", 64'(mmio.c2_tx.hdr.tid), 64'(e_tid));
            check_eq("rsp_data", mmio.c2_tx.data, e_data);
        end
        check_eq("rd_addr", 64'(rd_addr), m_src);
        check_eq("wr_addr", 64'(wr_addr), m_dst);
        check_eq("rd_len", rd_len, m_rlen);
        check_eq("wr_len", wr_len, m_wlen);
        if (begin_copy) pulse_cnt++;
        if (mmio.c2_tx.mmioRdValid) begin
            rsp_tid_q.push_back(mmio.c2_tx.hdr.tid);
            rsp_data_q.push_back(mmio.c2_tx.data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_outputs();
        @(negedge clk);
        mmio.sRx_c0 = '0;
        soft_reset  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_wr(input int off, input logic [63:0] d);
        mmio.sRx_c0.mmioWrValid    = 1'b1;
        mmio.sRx_c0.hdr.address    = dw(off);
        mmio.sRx_c0.data[63:0]     = d;
    endtask

    task automatic set_rd(input int off, input logic [8:0] tid);
        mmio.sRx_c0.mmioRdValid = 1'b1;
        mmio.sRx_c0.hdr.address = dw(off);
        mmio.sRx_c0.hdr.tid     = tid;
    endtask

    task automatic wr(input int off, input logic [63:0] d);
        set_wr(off, d);
        tick();
    endtask

    task automatic rd_get(input string tag, input int off,
                          input logic [63:0] exp);
        rsp_tid_q.delete();
        rsp_data_q.delete();
        set_rd(off, 9'h1A);
        tick();
        idle(2);
        check_eq({tag, "_cnt"}, 64'(rsp_data_q.size()), 64'd1);
        if (rsp_data_q.size() != 0)
            check_eq(tag, rsp_data_q[0], exp);
    endtask

    function automatic int pick_off();
        int k;
        k = $urandom_range(0, 11);
        if (k <= 7) return k * 8;
        if (k == 8) return 'h40;
        if (k == 9) return 4;
        if (k == 10) return -8;
        return 'h20;
    endfunction

    function automatic logic [63:0] pick_data(input int off);
        if (off == 0 || off == 8)
            return ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
        if (off == 'h10 || off == 'h18)
            return 64'($urandom_range(0, 6));
        if (off == 'h20)
            return 64'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    initial begin
        int op, off;
        model_reset();
        mmio.sRx_c0 = '0;
        finished    = 1'b0;
        soft_reset  = 1'b1;
        tick();
        soft_reset = 1'b1;
        tick();
        check_eq("rst_begin", 64'(begin_copy), 64'd0);
        check_eq("rst_c2_valid", 64'(mmio.c2_tx.mmioRdValid), 64'd0);
        check_eq("rst_c2_data", mmio.c2_tx.data, 64'd0);
        check_eq("rst_rd_len", rd_len, 64'd0);

        // descriptor and launch
        wr('h00, 64'h100);
        wr('h08, 64'h200);
        wr('h10, 64'd4);
        wr('h18, 64'd4);
        pulse_cnt = 0;
        wr('h20, 64'd1);
        check_eq("launch_pulse", 64'(begin_copy), 64'd1);
        idle(3);
        check_eq("pulse_once", 64'(pulse_cnt), 64'd1);
        check_eq("desc_src", 64'(rd_addr), 64'h100);
        check_eq("desc_dst", 64'(wr_addr), 64'h200);
        check_eq("desc_len", rd_len + wr_len, 64'd8);
        rd_get("status_busy", 'h28, 64'h1);
        finished = 1'b1;
        idle(4);
        rd_get("status_done", 'h28, 64'h2);
        rd_get("dones_1", 'h38, 64'd1);

        // guard window: finished already high at launch
        wr('h20, 64'd1);
        for (int i = 0; i < 8; i++) begin
            set_rd('h28, 9'(i));
            tick();
        end
        idle(2);
        rd_get("guard_cycles", 'h30, 64'd5);
        rd_get("dones_2", 'h38, 64'd2);

        // start validation
        finished = 1'b0;
        wr('h20, 64'd2);
        wr('h08, 64'd0);
        pulse_cnt = 0;
        wr('h20, 64'd1);
        rd_get("status_zero", 'h28, 64'h8);
        wr('h20, 64'd2);
        rd_get("status_clr", 'h28, 64'h0);
        wr('h08, 64'h200);
        wr('h10, 64'd2);
        wr('h18, 64'd3);
        wr('h20, 64'd1);
        rd_get("status_len", 'h28, 64'h10);
        check_eq("no_pulse", 64'(pulse_cnt), 64'd0);

        // writes and start while busy
        wr('h20, 64'd2);
        wr('h18, 64'd2);
        wr('h20, 64'd1);
        idle(6);
        pulse_cnt = 0;
        wr('h00, 64'h999);
        check_eq("busy_src_hold", 64'(rd_addr), 64'h100);
        wr('h20, 64'd1);
        idle(3);
        check_eq("busy_no_pulse", 64'(pulse_cnt), 64'd0);
        rd_get("status_wr_busy", 'h28, 64'h5);

        // back-to-back reads
        rsp_tid_q.delete();
        rsp_data_q.delete();
        set_rd('h28, 9'd1); tick();
        set_rd('h30, 9'd2); tick();
        set_rd('h40, 9'd3); tick();
        set_rd('h20, 9'd4); tick();
        idle(2);
        check_eq("b2b_cnt", 64'(rsp_tid_q.size()), 64'd4);
        if (rsp_tid_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check_eq("b2b_tid", 64'(rsp_tid_q[i]), 64'(i + 1));
            check_eq("unmapped_data", rsp_data_q[2], 64'd0);
            check_eq("ctrl_data", rsp_data_q[3], 64'd0);
        end

        // reset mid-run with a read in the reset cycle
        rsp_tid_q.delete();
        rsp_data_q.delete();
        soft_reset = 1'b1;
        set_rd('h28, 9'd5);
        tick();
        check_eq("rr_begin", 64'(begin_copy), 64'd0);
        check_eq("rr_rd_addr", 64'(rd_addr), 64'd0);
        check_eq("rr_wr_len", wr_len, 64'd0);
        idle(3);
        check_eq("rr_no_rsp", 64'(rsp_tid_q.size()), 64'd0);
        rd_get("rr_status", 'h28, 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            finished = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) soft_reset = 1'b1;
            op  = $urandom_range(0, 9);
            off = pick_off();
            if (op <= 3 || op == 7) set_wr(off, pick_data(off));
            if (op >= 4 && op <= 7) set_rd(off, 9'($urandom));
            tick();
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_csr_ctrl.md
# dma_csr_ctrl

MMIO control/status front end for the `dma` copy engine. It decodes CCI-P MMIO writes into a copy descriptor: source and destination cache-line addresses plus read and write lengths. On a start command it pulses `begin_copy` to `dma`, tracks the run until `dma` reports `finished`, and serves MMIO reads of status and performance counters. It sits directly upstream of `dma` and drives its descriptor inputs.

## Interface
Parameters:
- `GUARD_CYCLES`, 3: cycles after launch during which `finished` is ignored; covers the registered reset inside `dma`.
- `CSR_BASE`, 16'h0020: byte offset of the first descriptor register.

Ports:
- `clk` input 1: single clock.
- `soft_reset` input 1: reset is synchronous and active-high.
- `sRx_c0` input `t_if_ccip_c0_Rx`: uses `mmioWrValid`, `mmioRdValid`, `hdr.address` (dword index), `hdr.tid`, `data[63:0]`.
- `c2_tx` output `t_if_ccip_c2_Tx`: MMIO read response.
- `begin_copy` output 1: one-cycle launch pulse to `dma`.
- `rd_addr` output `t_ccip_clAddr`: source cache-line address.
- `wr_addr` output `t_ccip_clAddr`: destination cache-line address.
- `rd_len` output 64: number of lines to read.
- `wr_len` output 64: number of lines to write.
- `finished` input 1: from `dma`; level signal, high when the copy is complete.

## Operation
- Register map. Byte offset = `hdr.address`×4; all registers are 64-bit.
  - SRC at base+0x00, DST at +0x08, RLEN at +0x10, WLEN at +0x18.
  - CTRL at +0x20 (write-only).
  - STATUS at +0x28.
  - CYCLES at +0x30.
  - DONES at +0x38.
- SRC and DST keep the low 42 bits. Reading them returns the value zero-extended to 64 bits.
- CTRL bits:
  - bit0 start.
  - bit1 clear-status, which clears DONE and all error bits.
  - If bit0 and bit1 are written together, the clear is applied first, then the start.
- STATUS bits:
  - bit0 BUSY: state is LAUNCH, GUARD or BUSY.
  - bit1 DONE.
  - bit2 ERR_WR_BUSY.
  - bit3 ERR_ZERO_ADDR.
  - bit4 ERR_LEN.
  - Error bits are sticky.
- A descriptor write while BUSY is dropped and sets ERR_WR_BUSY. A start while BUSY is also dropped and sets ERR_WR_BUSY.
- Start validation, applied when the start comes from IDLE or DONE:
  - SRC==0 or DST==0: set ERR_ZERO_ADDR, no launch.
  - WLEN>RLEN: set ERR_LEN, no launch.
  - Otherwise: launch.
- States: IDLE, LAUNCH, GUARD, BUSY, DONE.
  - IDLE/DONE → LAUNCH on a valid start; the DONE bit is cleared.
  - LAUNCH (1 cycle, `begin_copy`=1) → GUARD.
  - GUARD: counts `GUARD_CYCLES` cycles, then → BUSY.
  - BUSY → DONE when `finished`=1; DONE bit is set.
- CYCLES:
  - Cleared to 0 on entry to LAUNCH.
  - Increments every cycle in LAUNCH, GUARD and BUSY.
  - Saturates at 2^64−1.
- DONES increments on each BUSY→DONE transition and wraps modulo 2^64.
- Reads of unmapped offsets return 0. Writes to unmapped offsets are ignored. A read of CTRL returns 0.
- Descriptor outputs are driven continuously from the registers. They are held constant from LAUNCH until DONE.

## Timing
- MMIO write valid at cycle T: the register updates at T+1.
- Start written at T (valid): `begin_copy`=1 at T+1 only.
- BUSY is entered at T+2+`GUARD_CYCLES`. `finished` is first sampled in that cycle.
- `finished` sampled high at cycle F: state is DONE and DONES is updated at F+1.
- MMIO read valid at cycle R:
  - `c2_tx.mmioRdValid`=1 at R+2, for exactly one cycle.
  - `hdr.tid` is echoed from the request.
  - Data reflects register values as of cycle R+1. Same-cycle updates are not visible.
- A read and a write in the same cycle are both serviced.
- Back-to-back reads on consecutive cycles give back-to-back responses, with no stall.
- Reset values:
  - All registers 0.
  - State IDLE.
  - `begin_copy`=0.
  - `c2_tx`=0.
  - All descriptor outputs 0.
- `soft_reset` mid-run:
  - Returns to IDLE next cycle.
  - No `begin_copy` is emitted.
  - Any pending read response is dropped.

## Structure
- Shared package `dma_csr_pkg`:
  - Register offset constants.
  - STATUS bit indices.
  - CTRL bit indices.
  - State enum `t_csr_state`.
- Uses the existing CCI-P types from `dma.vh`.
- Single flat module. No sub-module is warranted.

## Test plan
- Descriptor and launch:
  - Stimulus: write SRC=0x100, DST=0x200, RLEN=WLEN=4, then CTRL=1.
  - Required: `begin_copy` high for exactly one cycle, with outputs at 0x100/0x200/4/4.
  - Required: STATUS reads 0x1; after `finished` rises, STATUS reads 0x2 and DONES reads 1.
- Start validation:
  - Stimulus: start with DST=0.
  - Required: no pulse, STATUS=0x8. Then CTRL=2 → STATUS=0x0.
  - Stimulus: start with RLEN=2, WLEN=3.
  - Required: STATUS=0x10, no pulse.
- Writes while busy:
  - Stimulus: write SRC=0x999 while BUSY.
  - Required: `rd_addr` unchanged and ERR_WR_BUSY set.
  - Stimulus: a second start while BUSY.
  - Required: no extra pulse.
- Guard window:
  - Stimulus: hold `finished`=1 throughout LAUNCH and GUARD.
  - Required: DONE is not set before cycle T+2+3. CYCLES at DONE is 5.
- Read protocol:
  - Stimulus: reads of STATUS, CYCLES, an unmapped offset, and CTRL with tids 1, 2, 3, 4 on consecutive cycles.
  - Required: four responses at R+2 in order, with tids echoed; the unmapped and CTRL responses carry data 0.
- Reset mid-run:
  - Stimulus: assert `soft_reset` in BUSY.
  - Required: all outputs 0 next cycle and state IDLE.
  - Stimulus: a read issued in the reset cycle.
  - Required: no response.
